// File: rtl/ifmap_pkg.sv
// Shared types and constants for the input-feature-map AXI read address generator.
package ifmap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic tile_last;
        logic job_last;
    } burst_flag_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         BOUNDARY_4K    = 4096;

endpackage

// File: rtl/burst_flag_fifo.sv
// Small FIFO carrying per-burst end-of-tile / end-of-job flags
// from the AR channel to the R channel.
module burst_flag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [W-1:0]    mem_q [DEPTH];
    logic [PW-1:0]   wr_q;
    logic [PW-1:0]   rd_q;
    logic [CNTW-1:0] cnt_q;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNTW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= ptr_inc(wr_q);
            end
            if (do_pop) begin
                rd_q <= ptr_inc(rd_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNTW'(1);
                2'b01:   cnt_q <= cnt_q - CNTW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ifmap_rd_addr_gen.sv
// AXI4 read-address generator walking tiles/rows of a feature map in
// 4 KB-safe INCR bursts, with outstanding-burst limit and tile/job end flags.
module ifmap_rd_addr_gen
    import ifmap_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_LEN = 16,
    parameter int MAX_OUT   = 4,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] cfg_base,
    input  logic [CW-1:0] cfg_row_bytes,
    input  logic [AW-1:0] cfg_row_pitch,
    input  logic [AW-1:0] cfg_tile_step,
    input  logic [CW-1:0] cfg_rows,
    input  logic [CW-1:0] cfg_tiles,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] araddr,
    output logic [7:0]    arlen,
    output logic [2:0]    arsize,
    output logic [1:0]    arburst,
    output logic          arvalid,
    input  logic          arready,
    input  logic          rvalid,
    input  logic          rready,
    input  logic          rlast,
    output logic          blkend,
    output logic          mapend
);

    localparam int BYTES = DW / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int LW    = ((CW > 13) ? CW : 13) + 1;
    localparam int OCW   = $clog2(MAX_OUT + 1);

    state_e        state_q;
    logic          busy_q;
    logic          done_q;
    logic          arvalid_q;
    logic [AW-1:0] araddr_q;
    logic [7:0]    arlen_q;
    logic          blkend_q;
    logic          mapend_q;
    logic [OCW-1:0] out_q;
    logic [OCW-1:0] out_d;
    burst_flag_t   flag_q;

    logic [AW-1:0] pitch_q;
    logic [AW-1:0] step_q;
    logic [CW-1:0] rbeats_q;
    logic [CW-1:0] rows_cfg_q;

    logic [AW-1:0] addr_q;
    logic [AW-1:0] row_base_q;
    logic [AW-1:0] tile_base_q;
    logic [CW-1:0] beats_q;
    logic [CW-1:0] rows_q;
    logic [CW-1:0] tiles_q;

    logic          idle;
    logic [CW-1:0] cfg_beats;
    logic          cfg_bad;

    logic [AW-1:0] s_addr;
    logic [AW-1:0] s_row_base;
    logic [AW-1:0] s_tile_base;
    logic [CW-1:0] s_beats;
    logic [CW-1:0] s_rows;
    logic [CW-1:0] s_tiles;
    logic [AW-1:0] c_pitch;
    logic [AW-1:0] c_step;
    logic [CW-1:0] c_rbeats;
    logic [CW-1:0] c_rows;

    logic [LW-1:0] b4k;
    logic [LW-1:0] to4k;
    logic [LW-1:0] len;
    logic [CW-1:0] rem;

    logic [AW-1:0] n_addr;
    logic [AW-1:0] n_row_base;
    logic [AW-1:0] n_tile_base;
    logic [CW-1:0] n_beats;
    logic [CW-1:0] n_rows;
    logic [CW-1:0] n_tiles;
    burst_flag_t   n_flag;

    logic          inc;
    logic          rpop;
    logic          dec;
    logic          can_load;
    logic          load_now;
    burst_flag_t   pop_flag;
    logic          fifo_empty;
    logic          fifo_full;

    assign idle      = (state_q == IDLE);
    assign cfg_beats = cfg_row_bytes >> BSH;
    assign cfg_bad   = (cfg_beats == '0) | (cfg_rows == '0) | (cfg_tiles == '0);

    // In IDLE the first burst is computed straight from the config inputs.
    assign s_addr      = idle ? cfg_base  : addr_q;
    assign s_row_base  = idle ? cfg_base  : row_base_q;
    assign s_tile_base = idle ? cfg_base  : tile_base_q;
    assign s_beats     = idle ? cfg_beats : beats_q;
    assign s_rows      = idle ? cfg_rows  : rows_q;
    assign s_tiles     = idle ? cfg_tiles : tiles_q;
    assign c_pitch     = idle ? cfg_row_pitch : pitch_q;
    assign c_step      = idle ? cfg_tile_step : step_q;
    assign c_rbeats    = idle ? cfg_beats : rbeats_q;
    assign c_rows      = idle ? cfg_rows  : rows_cfg_q;

    always_comb begin
        b4k  = LW'(BOUNDARY_4K) - LW'(s_addr[11:0]);
        to4k = b4k >> BSH;
        len  = LW'(BURST_LEN);
        if (LW'(s_beats) < len) len = LW'(s_beats);
        if (to4k < len) len = to4k;
    end

    always_comb begin
        rem         = s_beats - CW'(len);
        n_addr      = s_addr + (AW'(len) << BSH);
        n_row_base  = s_row_base;
        n_tile_base = s_tile_base;
        n_beats     = rem;
        n_rows      = s_rows;
        n_tiles     = s_tiles;
        n_flag      = '0;
        if (rem == '0) begin
            if (s_rows > CW'(1)) begin
                n_row_base = s_row_base + c_pitch;
                n_addr     = n_row_base;
                n_beats    = c_rbeats;
                n_rows     = s_rows - CW'(1);
            end else begin
                n_flag.tile_last = 1'b1;
                if (s_tiles > CW'(1)) begin
                    n_tile_base = s_tile_base + c_step;
                    n_row_base  = n_tile_base;
                    n_addr      = n_tile_base;
                    n_beats     = c_rbeats;
                    n_rows      = c_rows;
                    n_tiles     = s_tiles - CW'(1);
                end else begin
                    n_flag.job_last = 1'b1;
                end
            end
        end
    end

    assign inc  = arvalid_q & arready;
    assign rpop = rvalid & rready & rlast;
    assign dec  = rpop & ~fifo_empty;

    always_comb begin
        unique case ({inc, dec})
            2'b10:   out_d = out_q + OCW'(1);
            2'b01:   out_d = out_q - OCW'(1);
            default: out_d = out_q;
        endcase
    end

    assign can_load = (out_d < OCW'(MAX_OUT));

    // A new burst is loaded into the AR registers whenever room exists.
    always_comb begin
        load_now = 1'b0;
        unique case (state_q)
            IDLE:    load_now = start & ~cfg_bad;
            ISSUE:   load_now = can_load &
                                (~arvalid_q | (arready & ~flag_q.job_last));
            default: load_now = 1'b0;
        endcase
    end

    burst_flag_fifo #(
        .DEPTH (MAX_OUT),
        .W     (2)
    ) u_flags (
        .clk   (clk),
        .rst   (rst),
        .push  (inc & (~fifo_full | rpop)),
        .wdata (flag_q),
        .pop   (rpop),
        .rdata (pop_flag),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            blkend_q    <= 1'b0;
            mapend_q    <= 1'b0;
            out_q       <= '0;
            flag_q      <= '0;
            pitch_q     <= '0;
            step_q      <= '0;
            rbeats_q    <= '0;
            rows_cfg_q  <= '0;
            addr_q      <= '0;
            row_base_q  <= '0;
            tile_base_q <= '0;
            beats_q     <= '0;
            rows_q      <= '0;
            tiles_q     <= '0;
        end else begin
            done_q   <= 1'b0;
            blkend_q <= dec & pop_flag.tile_last;
            mapend_q <= dec & pop_flag.job_last;
            out_q    <= out_d;

            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            done_q <= 1'b1;
                        end else begin
                            pitch_q    <= cfg_row_pitch;
                            step_q     <= cfg_tile_step;
                            rbeats_q   <= cfg_beats;
                            rows_cfg_q <= cfg_rows;
                            busy_q     <= 1'b1;
                            state_q    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (inc && flag_q.job_last) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (load_now) begin
                arvalid_q   <= 1'b1;
                araddr_q    <= s_addr;
                arlen_q     <= 8'(len - LW'(1));
                flag_q      <= n_flag;
                addr_q      <= n_addr;
                row_base_q  <= n_row_base;
                tile_base_q <= n_tile_base;
                beats_q     <= n_beats;
                rows_q      <= n_rows;
                tiles_q     <= n_tiles;
            end else if (inc) begin
                arvalid_q <= 1'b0;
            end
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arsize  = 3'(BSH);
    assign arburst = AXI_BURST_INCR;
    assign arvalid = arvalid_q;
    assign blkend  = blkend_q;
    assign mapend  = mapend_q;

endmodule

// File: tb/tb_ifmap_rd_addr_gen.sv
// Directed bench for ifmap_rd_addr_gen: acts as AXI slave and checks
// AR sequence, outstanding limit, tile/job end flags and reset behaviour.
module tb_ifmap_rd_addr_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_base = '0;
    logic [15:0] cfg_row_bytes = '0;
    logic [31:0] cfg_row_pitch = '0;
    logic [31:0] cfg_tile_step = '0;
    logic [15:0] cfg_rows = '0;
    logic [15:0] cfg_tiles = '0;
    logic        busy;
    logic        done;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b1;
    logic        rvalid = 1'b0;
    logic        rready = 1'b1;
    logic        rlast = 1'b0;
    logic        blkend;
    logic        mapend;

    int checks = 0;
    int errors = 0;

    logic [39:0] ar_log[$];
    int          pend[$];
    int          blk_log[$];
    int          map_log[$];
    int          done_n = 0;
    int          rlast_n = 0;
    int          max_os = 0;
    int          cur_left = 0;
    int          r_budget = 1 << 20;

    ifmap_rd_addr_gen dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_base      (cfg_base),
        .cfg_row_bytes (cfg_row_bytes),
        .cfg_row_pitch (cfg_row_pitch),
        .cfg_tile_step (cfg_tile_step),
        .cfg_rows      (cfg_rows),
        .cfg_tiles     (cfg_tiles),
        .busy          (busy),
        .done          (done),
        .araddr        (araddr),
        .arlen         (arlen),
        .arsize        (arsize),
        .arburst       (arburst),
        .arvalid       (arvalid),
        .arready       (arready),
        .rvalid        (rvalid),
        .rready        (rready),
        .rlast         (rlast),
        .blkend        (blkend),
        .mapend        (mapend)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Observe handshakes and flag pulses away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (blkend) blk_log.push_back(rlast_n);
            if (mapend) map_log.push_back(rlast_n);
            if (done) done_n++;
            if (arvalid && arready) begin
                ar_log.push_back({araddr, arlen});
                pend.push_back(int'(arlen));
            end
            if (rvalid && rready && rlast) rlast_n++;
            if (int'(ar_log.size()) - rlast_n > max_os)
                max_os = int'(ar_log.size()) - rlast_n;
        end
    end

    // R-channel slave: returns bursts in order, gated by r_budget.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            rvalid   = 1'b0;
            rlast    = 1'b0;
            cur_left = 0;
            pend.delete();
        end else begin
            if (rvalid) cur_left--;
            if (cur_left == 0 && pend.size() > 0 && r_budget > 0) begin
                cur_left = pend.pop_front() + 1;
                r_budget--;
            end
            rvalid = (cur_left > 0);
            rlast  = (cur_left == 1);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ar(input string tag, input int idx,
                          input logic [31:0] a, input logic [7:0] l);
        logic [39:0] obs;
        obs = (idx < ar_log.size()) ? ar_log[idx] : 40'hff_ffff_ffff;
        chk(tag, 64'(obs), 64'({a, l}));
    endtask

    task automatic clear_logs();
        ar_log.delete();
        blk_log.delete();
        map_log.delete();
        done_n  = 0;
        rlast_n = 0;
        max_os  = 0;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] rb,
                            input logic [31:0] p, input logic [31:0] s,
                            input logic [15:0] rows, input logic [15:0] tiles);
        @(posedge clk);
        #1;
        cfg_base      = b;
        cfg_row_bytes = rb;
        cfg_row_pitch = p;
        cfg_tile_step = s;
        cfg_rows      = rows;
        cfg_tiles     = tiles;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int n = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " done seen"}, 64'(done), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic basic_job_checks(input string tag);
        chk({tag, " ar count"}, 64'(ar_log.size()), 64'd3);
        chk_ar({tag, " ar0"}, 0, 32'h1000, 8'd15);
        chk_ar({tag, " ar1"}, 1, 32'h1100, 8'd15);
        chk_ar({tag, " ar2"}, 2, 32'h1200, 8'd15);
        chk({tag, " blkend count"}, 64'(blk_log.size()), 64'd1);
        chk({tag, " blkend at"}, 64'(blk_log.size() ? blk_log[0] : -1), 64'd3);
        chk({tag, " mapend at"}, 64'(map_log.size() ? map_log[0] : -1), 64'd3);
        chk({tag, " done pulses"}, 64'(done_n), 64'd1);
        chk({tag, " busy after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst arvalid", 64'(arvalid), 64'd0);
        chk("rst araddr", 64'(araddr), 64'd0);
        chk("rst arlen", 64'(arlen), 64'd0);
        chk("rst blkend", 64'(blkend), 64'd0);
        chk("rst mapend", 64'(mapend), 64'd0);
        chk("arsize", 64'(arsize), 64'd2);
        chk("arburst", 64'(arburst), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic job
        clear_logs();
        do_start(32'h1000, 16'd64, 32'h100, 32'h0, 16'd3, 16'd1);
        @(negedge clk);
        chk("basic busy", 64'(busy), 64'd1);
        chk("basic first arvalid", 64'(arvalid), 64'd1);
        chk("basic first araddr", 64'(araddr), 64'h1000);
        wait_done("basic", 300);
        basic_job_checks("basic");

        // Row split
        clear_logs();
        do_start(32'h1000, 16'd96, 32'h100, 32'h0, 16'd1, 16'd1);
        wait_done("split", 300);
        chk("split ar count", 64'(ar_log.size()), 64'd2);
        chk_ar("split ar0", 0, 32'h1000, 8'd15);
        chk_ar("split ar1", 1, 32'h1040, 8'd7);
        chk("split mapend at", 64'(map_log.size() ? map_log[0] : -1), 64'd2);

        // 4 KB boundary
        clear_logs();
        do_start(32'h0FF0, 16'd64, 32'h100, 32'h0, 16'd1, 16'd1);
        wait_done("4k", 300);
        chk("4k ar count", 64'(ar_log.size()), 64'd2);
        chk_ar("4k ar0", 0, 32'h0FF0, 8'd3);
        chk_ar("4k ar1", 1, 32'h1000, 8'd11);

        // Multi-tile
        clear_logs();
        do_start(32'h0, 16'd64, 32'h100, 32'h40, 16'd2, 16'd2);
        wait_done("tile", 400);
        chk("tile ar count", 64'(ar_log.size()), 64'd4);
        chk_ar("tile ar0", 0, 32'h000, 8'd15);
        chk_ar("tile ar1", 1, 32'h100, 8'd15);
        chk_ar("tile ar2", 2, 32'h040, 8'd15);
        chk_ar("tile ar3", 3, 32'h140, 8'd15);
        chk("tile blkend count", 64'(blk_log.size()), 64'd2);
        chk("tile blkend 1st", 64'(blk_log.size() > 0 ? blk_log[0] : -1), 64'd2);
        chk("tile blkend 2nd", 64'(blk_log.size() > 1 ? blk_log[1] : -1), 64'd4);
        chk("tile mapend count", 64'(map_log.size()), 64'd1);
        chk("tile mapend at", 64'(map_log.size() ? map_log[0] : -1), 64'd4);

        // Outstanding cap with R held off
        clear_logs();
        r_budget = 0;
        do_start(32'h2000, 16'd64, 32'h100, 32'h0, 16'd8, 16'd1);
        repeat (30) @(negedge clk);
        chk("cap ar count 4", 64'(ar_log.size()), 64'd4);
        chk("cap arvalid low", 64'(arvalid), 64'd0);
        r_budget = 1;
        repeat (40) @(negedge clk);
        chk("cap ar count 5", 64'(ar_log.size()), 64'd5);
        chk("cap arvalid low 2", 64'(arvalid), 64'd0);
        r_budget = 1;
        repeat (40) @(negedge clk);
        chk("cap ar count 6", 64'(ar_log.size()), 64'd6);
        r_budget = 1 << 20;
        wait_done("cap", 400);
        chk("cap ar count 8", 64'(ar_log.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            chk_ar($sformatf("cap ar%0d", i), i, 32'h2000 + 32'(i) * 32'h100, 8'd15);
        chk("cap max outstanding", 64'(max_os <= 4), 64'd1);
        chk("cap mapend at", 64'(map_log.size() ? map_log[0] : -1), 64'd8);

        // Zero-size config completes immediately
        clear_logs();
        do_start(32'h1000, 16'd64, 32'h100, 32'h0, 16'd0, 16'd1);
        @(negedge clk);
        chk("zero done", 64'(done), 64'd1);
        chk("zero busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("zero done pulse", 64'(done), 64'd0);
        repeat (5) @(negedge clk);
        chk("zero no ar", 64'(ar_log.size()), 64'd0);
        chk("zero no flags", 64'(blk_log.size() + map_log.size()), 64'd0);

        // Start while busy is ignored
        clear_logs();
        do_start(32'h1000, 16'd64, 32'h100, 32'h0, 16'd3, 16'd1);
        repeat (2) @(posedge clk);
        #1;
        cfg_base = 32'h5000;
        cfg_rows = 16'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("busystart", 300);
        basic_job_checks("busystart");

        // Reset while arvalid is held without arready
        clear_logs();
        arready = 1'b0;
        do_start(32'h1000, 16'd64, 32'h100, 32'h0, 16'd3, 16'd1);
        repeat (3) @(negedge clk);
        chk("hold arvalid", 64'(arvalid), 64'd1);
        chk("hold araddr", 64'(araddr), 64'h1000);
        chk("hold arlen", 64'(arlen), 64'd15);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort arvalid", 64'(arvalid), 64'd0);
        chk("abort busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        arready = 1'b1;
        clear_logs();
        do_start(32'h1000, 16'd64, 32'h100, 32'h0, 16'd3, 16'd1);
        wait_done("rerun", 300);
        basic_job_checks("rerun");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifmap_rd_addr_gen.md
Name: ifmap_rd_addr_gen

Overview:
- Parametrised AXI4 read-address generator for the input buffer. It is the next generation of the fixed-stride burst address generator.
- Fetches a feature-map job: cfg_tiles tiles, each cfg_rows rows of cfg_row_bytes bytes, rows cfg_row_pitch apart.
- Splits rows into INCR bursts of at most BURST_LEN beats, never crossing a 4 KB boundary, with bounded outstanding bursts.
- Tracks R-channel completion to emit blkend per tile and mapend per job.

Parameters:
- AW, 32, address width.
- DW, 32, AXI data width in bits; BYTES = DW/8 (power of two).
- BURST_LEN, 16, maximum beats per burst (1..256).
- MAX_OUT, 4, maximum outstanding bursts (power of two, >=1).
- CW, 16, width of the count/size config fields.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle job start; ignored while busy.
- cfg_base  in  AW  first row byte address (BYTES-aligned).
- cfg_row_bytes  in  CW  bytes per row (multiple of BYTES).
- cfg_row_pitch  in  AW  byte step between rows of a tile.
- cfg_tile_step  in  AW  byte step between tile base addresses.
- cfg_rows  in  CW  rows per tile.
- cfg_tiles  in  CW  tiles per job.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the job has fully retired.
- araddr  out  AW  burst address.
- arlen  out  8  beats-1.
- arsize  out  3  log2(BYTES), constant.
- arburst  out  2  2'b01 (INCR), constant.
- arvalid  out  1  address valid.
- arready  in  1  address accepted.
- rvalid, rready, rlast  in  1 each  R-channel monitor; a beat is retired on rvalid&rready.
- blkend  out  1  pulse on the final R beat of each tile.
- mapend  out  1  pulse on the final R beat of the job (coincides with the last blkend).

Behaviour:
- Reset: busy, done, arvalid, blkend and mapend are 0. araddr and arlen are 0. FSM is in IDLE. All counters and the flag FIFO are cleared.
- Reset mid-job aborts immediately. No recovery of in-flight bursts; the AXI slave is reset with the block.
- FSM has three states: IDLE, ISSUE, DRAIN.
- IDLE, start=1, any cfg_rows/cfg_tiles/cfg_row_bytes equal to 0:
  - Next cycle: done=1, busy stays 0.
  - No AR is issued; blkend and mapend stay 0.
- IDLE, start=1, valid config:
  - Latch all cfg_* fields, set busy=1, go to ISSUE.
  - First arvalid asserts the cycle after start.
- ISSUE: burst length is len = min(BURST_LEN, beats left in row, (4096 - addr[11:0])/BYTES).
- arvalid, araddr and arlen stay stable until arready.
- After a handshake, the next burst may present on the following cycle (back-to-back).
- arvalid is not newly asserted while outstanding == MAX_OUT. Once asserted it is never withdrawn.
- Address walk:
  - Within a row, addr += len*BYTES.
  - At row end, row_base += cfg_row_pitch.
  - At tile end, tile_base += cfg_tile_step and row_base = tile_base.
  - All arithmetic is modulo 2^AW.
- When the last burst of the job is accepted, go to DRAIN.
- DRAIN: wait until outstanding == 0, then pulse done, clear busy, go to IDLE. A start in that same cycle is ignored.
- Outstanding counter:
  - +1 on AR handshake; -1 on a retired beat with rlast.
  - Both in the same cycle leave it unchanged.
  - Never exceeds MAX_OUT.
- Flag FIFO:
  - Each accepted burst pushes {tile_last, job_last}.
  - An rlast beat pops the FIFO.
  - blkend = popped tile_last, mapend = popped job_last, both registered (one cycle after the rlast beat).
- Non-rlast beats have no effect. An rlast with an empty FIFO is an assertion error (bench checks).

Decomposition:
- Package ifmap_pkg: fsm state enum (IDLE/ISSUE/DRAIN), AXI_BURST_INCR = 2'b01, BOUNDARY_4K = 4096.
- Sub-module burst_flag_fifo: depth MAX_OUT, width 2, push/pop/empty/full.

Test Plan:
- Basic job: base 0x1000, row_bytes 64, pitch 0x100, rows 3, tiles 1, arready=1, R data immediate.
  - Expect ARs at 0x1000, 0x1100, 0x1200, each arlen=15.
  - blkend and mapend pulse once, after the 3rd rlast; then done.
- Row split: row_bytes 96, rows 1 -> two ARs: 0x1000 arlen=15, then 0x1040 arlen=7.
- 4 KB boundary: base 0x0FF0, row_bytes 64 -> AR 0x0FF0 arlen=3, then AR 0x1000 arlen=11.
- Outstanding cap: MAX_OUT=4, 8-burst job, rvalid held low.
  - Expect exactly 4 AR handshakes, then arvalid=0.
  - Each retired rlast admits exactly one more AR.
- Multi-tile: tiles 2, rows 2, row_bytes 64, pitch 0x100, tile_step 0x40, base 0.
  - Expect ARs 0x000, 0x100, 0x040, 0x140.
  - blkend on the 2nd and 4th rlast; mapend only on the 4th.
- Reset/start robustness:
  - Pulse start while busy -> ignored, AR sequence unchanged.
  - Assert rst while arvalid=1 and arready=0 -> arvalid=0 and busy=0 immediately.
  - A new start after rst deasserts runs the basic job correctly.
